// File: rtl/light_seq_if.sv
// Control/status bundle for the traffic-light sequencer: start/stop requests in,
// lamp drive and phase status out.
interface light_seq_if;
  logic       start;
  logic       stop;
  logic [2:0] led;
  logic [2:0] sec_cnt;
  logic       phase_done;
  logic       busy;

  modport master (
    output start,
    output stop,
    input  led,
    input  sec_cnt,
    input  phase_done,
    input  busy
  );

  modport slave (
    input  start,
    input  stop,
    output led,
    output sec_cnt,
    output phase_done,
    output busy
  );
endinterface

// File: rtl/light_seq_ctrl.sv
// Traffic-light sequencer: GREEN -> YELLOW -> RED -> GREEN, each phase DUR seconds long,
// timed by a prescaler that produces a one-cycle tick every F clock cycles.
module light_seq_ctrl #(
  parameter int F     = 100000000,
  parameter int G_SEC = 5,
  parameter int Y_SEC = 2,
  parameter int R_SEC = 4
) (
  input logic        clk,
  input logic        rst_n,
  light_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } state_t;

  localparam logic [29:0] PRESC_LAST = 30'(F - 1);
  localparam logic [2:0]  G_LAST     = 3'(G_SEC - 1);
  localparam logic [2:0]  Y_LAST     = 3'(Y_SEC - 1);
  localparam logic [2:0]  R_LAST     = 3'(R_SEC - 1);

  state_t      state;
  logic [29:0] presc;
  logic        tick;
  logic [2:0]  sec_last;

  function automatic logic [2:0] last_sec(input state_t s);
    logic [2:0] r;
    r = 3'd0;
    unique case (s)
      GREEN:   r = G_LAST;
      YELLOW:  r = Y_LAST;
      RED:     r = R_LAST;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic state_t next_phase(input state_t s);
    state_t r;
    r = IDLE;
    unique case (s)
      GREEN:   r = YELLOW;
      YELLOW:  r = RED;
      RED:     r = GREEN;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] lamp(input state_t s);
    logic [2:0] r;
    r = 3'b000;
    unique case (s)
      GREEN:   r = 3'b001;
      YELLOW:  r = 3'b010;
      RED:     r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  always_comb begin
    tick     = (state != IDLE) && (presc == PRESC_LAST);
    sec_last = last_sec(state);
  end

  // stop outranks everything, including a tick that would advance the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      presc          <= 30'd0;
      bus.sec_cnt    <= 3'd0;
      bus.led        <= 3'b000;
      bus.phase_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.phase_done <= 1'b0;
      if (state == IDLE) begin
        presc       <= 30'd0;
        bus.sec_cnt <= 3'd0;
        if (bus.start && !bus.stop) begin
          state    <= GREEN;
          bus.led  <= lamp(GREEN);
          bus.busy <= 1'b1;
        end
      end else if (bus.stop) begin
        state       <= IDLE;
        presc       <= 30'd0;
        bus.sec_cnt <= 3'd0;
        bus.led     <= 3'b000;
        bus.busy    <= 1'b0;
      end else if (tick) begin
        presc <= 30'd0;
        if (bus.sec_cnt == sec_last) begin
          state          <= next_phase(state);
          bus.led        <= lamp(next_phase(state));
          bus.sec_cnt    <= 3'd0;
          bus.phase_done <= 1'b1;
        end else begin
          bus.sec_cnt <= bus.sec_cnt + 3'd1;
        end
      end else begin
        presc <= presc + 30'd1;
      end
    end
  end

endmodule

// File: tb/tb_light_seq_ctrl.sv
// Bench for light_seq_ctrl with F=4, G=2, Y=1, R=3: start-up vector table, corner
// sequences and a randomized run against a cycle-count reference model.
module tb_light_seq_ctrl;

  localparam int F     = 4;
  localparam int G_SEC = 2;
  localparam int Y_SEC = 1;
  localparam int R_SEC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  light_seq_if bus ();

  light_seq_ctrl #(.F(F), .G_SEC(G_SEC), .Y_SEC(Y_SEC), .R_SEC(R_SEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: phase index and cycles spent in the phase; seconds = cycles / F.
  bit m_run;
  int m_p;
  int m_cyc;
  bit m_pd;

  function automatic int dur(input int p);
    return (p == 0) ? G_SEC : (p == 1) ? Y_SEC : R_SEC;
  endfunction

  task automatic model_reset();
    m_run = 0; m_p = 0; m_cyc = 0; m_pd = 0;
  endtask

  task automatic model_edge(input bit s, input bit p);
    m_pd = 0;
    if (!m_run) begin
      if (s && !p) begin m_run = 1; m_p = 0; m_cyc = 0; end
    end else if (p) begin
      m_run = 0;
    end else begin
      m_cyc++;
      if (m_cyc == dur(m_p) * F) begin
        m_p = (m_p + 1) % 3; m_cyc = 0; m_pd = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model.led", int'(bus.led), m_run ? (1 << m_p) : 0);
    chk("model.busy", int'(bus.busy), int'(m_run));
    chk("model.sec", int'(bus.sec_cnt), m_run ? (m_cyc / F) : 0);
    chk("model.pd", int'(bus.phase_done), int'(m_pd));
  endtask

  task automatic drive_edge(input bit s, input bit p);
    bus.start = s;
    bus.stop  = p;
    @(posedge clk);
    model_edge(s, p);
    #1;
    check_model();
  endtask

  task automatic check_all(input string name, input int led, input int busy,
                           input int sec, input int pd);
    chk({name, ".led"}, int'(bus.led), led);
    chk({name, ".busy"}, int'(bus.busy), busy);
    chk({name, ".sec"}, int'(bus.sec_cnt), sec);
    chk({name, ".pd"}, int'(bus.phase_done), pd);
  endtask

  typedef struct {
    bit         start;
    bit         stop;
    logic [2:0] led;
    bit         busy;
    bit         pd;
    logic [2:0] sec;
  } vec_t;

  vec_t vt[1:25];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pd_cnt;
    bit rs, rp;

    // Start-up expectations: edge k is the k-th rising edge after the start pulse is applied.
    for (int k = 1; k <= 25; k++) begin
      vt[k].start = (k == 1);
      vt[k].stop  = 1'b0;
      vt[k].busy  = 1'b1;
      vt[k].pd    = (k == 9) || (k == 13) || (k == 25);
      if (k < 9) begin
        vt[k].led = 3'b001; vt[k].sec = 3'((k - 1) / 4);
      end else if (k < 13) begin
        vt[k].led = 3'b010; vt[k].sec = 3'd0;
      end else if (k < 25) begin
        vt[k].led = 3'b100; vt[k].sec = 3'((k - 13) / 4);
      end else begin
        vt[k].led = 3'b001; vt[k].sec = 3'd0;
      end
    end

    model_reset();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_edge(1'b0, 1'b0);
    check_all("idle_after_reset", 0, 0, 0, 0);

    for (int k = 1; k <= 25; k++) begin
      drive_edge(vt[k].start, vt[k].stop);
      chk($sformatf("table%0d.led", k), int'(bus.led), int'(vt[k].led));
      chk($sformatf("table%0d.busy", k), int'(bus.busy), int'(vt[k].busy));
      chk($sformatf("table%0d.sec", k), int'(bus.sec_cnt), int'(vt[k].sec));
      chk($sformatf("table%0d.pd", k), int'(bus.phase_done), int'(vt[k].pd));
    end

    drive_edge(1'b0, 1'b1);
    check_all("stop_green", 0, 0, 0, 0);

    // Stop coinciding with the GREEN->YELLOW tick.
    drive_edge(1'b1, 1'b0);
    repeat (7) drive_edge(1'b0, 1'b0);
    check_all("pre_boundary", 1, 1, 1, 0);
    drive_edge(1'b0, 1'b1);
    check_all("stop_boundary", 0, 0, 0, 0);

    // start and stop together in IDLE: stop wins.
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 1'b1);
      chk("startstop.busy", int'(bus.busy), 0);
    end
    drive_edge(1'b1, 1'b0);
    check_all("release_stop", 1, 1, 0, 0);

    // Holding start through a full period must not restart anything.
    pd_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      drive_edge(1'b1, 1'b0);
      if (bus.phase_done) pd_cnt++;
    end
    chk("held_start.pd_count", pd_cnt, 3);
    check_all("held_start.period", 1, 1, 0, 1);

    repeat (14) drive_edge(1'b1, 1'b0);
    chk("mid_red.led", int'(bus.led), 4);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) drive_edge(1'b0, 1'b0);
    check_all("post_reset_idle", 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      rs = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 39) == 0);
      drive_edge(rs, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/light_seq_ctrl.md
LIGHT_SEQ_CTRL -- requirements
Module: light_seq_ctrl

Interface
REQ-001 Parameter F, default 100000000, SHALL set the clock cycles per 1-second tick (F >= 2).
REQ-002 Parameter G_SEC, default 5, SHALL set the GREEN phase length in seconds (1..7).
REQ-003 Parameter Y_SEC, default 2, SHALL set the YELLOW phase length in seconds (1..7).
REQ-004 Parameter R_SEC, default 4, SHALL set the RED phase length in seconds (1..7).
REQ-005 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 start  input  1  SHALL be a level request to leave IDLE and begin sequencing.
REQ-008 stop  input  1  SHALL be a level request to abort sequencing and return to IDLE.
REQ-009 led  output  3  SHALL be the one-hot lamp drive {red, yellow, green}; 000 in IDLE.
REQ-010 sec_cnt  output  3  SHALL be the whole seconds elapsed in the current phase.
REQ-011 phase_done  output  1  SHALL be a one-cycle pulse marking each phase-to-phase transition.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, GREEN, YELLOW, RED; all outputs registered.
REQ-014 led SHALL be 000 in IDLE, 001 in GREEN, 010 in YELLOW, 100 in RED.
REQ-015 A 30-bit prescaler SHALL count 0..F-1 only while busy; tick SHALL be internal, high for one cycle when the prescaler equals F-1, and the prescaler SHALL wrap to 0 on that cycle.
REQ-016 The prescaler and sec_cnt SHALL clear to 0 on every phase entry and on return to IDLE.
REQ-017 On tick, sec_cnt SHALL increment by 1 unless it equals DUR-1 for the current phase (DUR = G_SEC/Y_SEC/R_SEC).
REQ-018 On tick with sec_cnt == DUR-1, the FSM SHALL advance GREEN->YELLOW->RED->GREEN, clear sec_cnt, and pulse phase_done in that same register update.
REQ-019 Each phase SHALL last exactly DUR*F clock cycles; no cycle SHALL be gained or lost at a phase boundary.
REQ-020 In IDLE, start high SHALL move the FSM to GREEN at the next edge (1-cycle latency); led = 001 and busy = 1 from that edge.
REQ-021 stop high in any non-IDLE state SHALL force IDLE at the next edge, overriding a coincident tick or phase advance; phase_done SHALL NOT pulse.
REQ-022 start and stop high together in IDLE: the FSM SHALL stay in IDLE (stop has priority).
REQ-023 start while busy SHALL be ignored; holding start high SHALL NOT restart the current phase.
REQ-024 After stop releases, with start still high, the FSM SHALL re-enter GREEN on the following edge.
REQ-025 sec_cnt SHALL never exceed DUR-1 and SHALL never wrap past 7.

Reset
REQ-026 rst_n low SHALL immediately and asynchronously force IDLE, led = 000, sec_cnt = 0, phase_done = 0, busy = 0, and prescaler = 0.
REQ-027 Reset asserted mid-phase SHALL discard all progress; after release the block SHALL wait in IDLE for start.
REQ-028 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Verification (F=4, G_SEC=2, Y_SEC=1, R_SEC=3)
REQ-029 Start-up: 1-cycle start pulse at edge 0 -> led=001 and busy=1 at edge 1; led=010 at edge 9; led=100 at edge 13; led=001 at edge 25; phase_done high only at edges 9, 13 and 25.
REQ-030 sec_cnt trace: in GREEN, sec_cnt = 0 for edges 1-4 and 1 for edges 5-8, then 0 at edge 9.
REQ-031 Stop on boundary: assert stop in the cycle before edge 9 (the GREEN->YELLOW tick) -> IDLE and led=000 at edge 9; phase_done stays 0.
REQ-032 Simultaneous start+stop in IDLE for 3 cycles -> busy stays 0; drop stop with start held -> led=001 on the next edge.
REQ-033 Async reset: drive rst_n low mid-RED, between clk edges -> all outputs go to their reset values without waiting for a clock edge; after release, no activity until start.
REQ-034 Start held high through a full cycle -> no restart; the period stays (2+1+3)*4 = 24 cycles.
